// File: rtl/aes256_decrypt_iterative.sv
// AES-256 ECB inverse cipher on 128-bit AXI-Stream blocks.
// One inverse round per clock through a single reused round datapath;
// round keys come unlatched from the shared key expansion block.
module aes256_decrypt_iterative #(
  parameter  int unsigned ROUNDS = 14,
  localparam int unsigned BLK_W  = 128,
  localparam int unsigned CNT_W  = $clog2(ROUNDS)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ROUNDS:0][BLK_W-1:0] round_keys_i,
  input  logic                    round_keys_valid_i,
  input  logic [BLK_W-1:0]        aes_in_tdata,
  input  logic                    aes_in_tvalid,
  input  logic                    aes_in_tlast,
  output logic                    aes_in_tready,
  output logic [BLK_W-1:0]        aes_out_tdata,
  output logic                    aes_out_tvalid,
  output logic                    aes_out_tlast,
  input  logic                    aes_out_tready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // GF(2^8) multiply by x, reduction polynomial 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r rotates right by r; byte index within the block is 4*col+row
  function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] inv_sub_bytes(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    end
    return o;
  endfunction

  // One column times the inverse MixColumns matrix {0e 0b 0d 09}
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [3:0][7:0] a;
    logic [3:0][7:0] m09;
    logic [3:0][7:0] m0b;
    logic [3:0][7:0] m0d;
    logic [3:0][7:0] m0e;
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    a   = col;
    m09 = '0;
    m0b = '0;
    m0d = '0;
    m0e = '0;
    for (int k = 0; k < 4; k++) begin
      x2     = xtime(a[k]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m09[k] = x8 ^ a[k];
      m0b[k] = x8 ^ x2 ^ a[k];
      m0d[k] = x8 ^ x4 ^ a[k];
      m0e[k] = x8 ^ x4 ^ x2;
    end
    // a[3] is the top byte (row 0) of the column
    return {m0e[3] ^ m0b[2] ^ m0d[1] ^ m09[0],
            m09[3] ^ m0e[2] ^ m0b[1] ^ m0d[0],
            m0d[3] ^ m09[2] ^ m0e[1] ^ m0b[0],
            m0b[3] ^ m0d[2] ^ m09[1] ^ m0e[0]};
  endfunction

  function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  state_t             r_fsm;
  state_t             w_fsm_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [BLK_W-1:0]   r_state;
  logic [BLK_W-1:0]   w_state_nxt;
  logic               r_tlast;
  logic               w_tlast_nxt;
  logic               r_run;
  logic               w_in_ready;
  logic [BLK_W-1:0]   w_ark;
  logic [BLK_W-1:0]   w_round_mid;

  // Shared round datapath; the final round simply skips InvMixColumns
  assign w_ark       = inv_sub_bytes(inv_shift_rows(r_state)) ^ round_keys_i[r_cnt];
  assign w_round_mid = inv_mix_columns(w_ark);

  // r_run keeps tready low while reset is asserted even if keys are valid
  assign w_in_ready  = (r_fsm == S_IDLE) && round_keys_valid_i && r_run;

  // State register and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fsm   <= S_IDLE;
      r_cnt   <= '0;
      r_state <= '0;
      r_tlast <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      r_tlast <= w_tlast_nxt;
      r_run   <= 1'b1;
    end
  end

  // Next-state: accept, iterate rounds (abort on key loss), hold until drained
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    w_tlast_nxt = r_tlast;
    case (r_fsm)
      S_IDLE: begin
        if (aes_in_tvalid && w_in_ready) begin
          w_state_nxt = aes_in_tdata ^ round_keys_i[ROUNDS];
          w_tlast_nxt = aes_in_tlast;
          w_cnt_nxt   = CNT_W'(ROUNDS - 1);
          w_fsm_nxt   = S_ROUND;
        end
      end
      S_ROUND: begin
        if (!round_keys_valid_i) begin
          w_fsm_nxt = S_IDLE;
        end else if (r_cnt != '0) begin
          w_state_nxt = w_round_mid;
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = w_ark;
          w_fsm_nxt   = S_DONE;
        end
      end
      S_DONE: begin
        if (aes_out_tready) begin
          w_fsm_nxt = S_IDLE;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  assign aes_in_tready  = w_in_ready;
  assign aes_out_tvalid = (r_fsm == S_DONE);
  assign aes_out_tdata  = (r_fsm == S_DONE) ? r_state : '0;
  assign aes_out_tlast  = (r_fsm == S_DONE) && r_tlast;

endmodule

// File: tb/tb_aes256_decrypt_iterative.sv
// Directed bench for aes256_decrypt_iterative using NIST AES-256 vectors.
module tb_aes256_decrypt_iterative;

  logic                clk;
  logic                resetn;
  logic [14:0][127:0]  round_keys;
  logic                keys_valid;
  logic [127:0]        in_tdata;
  logic                in_tvalid;
  logic                in_tlast;
  logic                in_tready;
  logic [127:0]        out_tdata;
  logic                out_tvalid;
  logic                out_tlast;
  logic                out_tready;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    logic         last;
  } vec_t;

  vec_t vecs [5];

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  aes256_decrypt_iterative dut (
    .clk                (clk),
    .resetn             (resetn),
    .round_keys_i       (round_keys),
    .round_keys_valid_i (keys_valid),
    .aes_in_tdata       (in_tdata),
    .aes_in_tvalid      (in_tvalid),
    .aes_in_tlast       (in_tlast),
    .aes_in_tready      (in_tready),
    .aes_out_tdata      (out_tdata),
    .aes_out_tvalid     (out_tvalid),
    .aes_out_tlast      (out_tlast),
    .aes_out_tready     (out_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Reference AES-256 key schedule (forward cipher direction)
  function automatic logic [14:0][127:0] expand_key(input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [14:0][127:0] rk;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a block, wait for acceptance, confirm the block went busy
  task automatic send(input vec_t v, input bit hold);
    int w;
    @(negedge clk);
    round_keys = expand_key(v.key);
    keys_valid = 1'b1;
    in_tdata   = v.ct;
    in_tlast   = v.last;
    in_tvalid  = 1'b1;
    w = 0;
    while (!in_tready && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (w >= 64) chk("accept_timeout", 160'(in_tready), 160'(1));
    @(posedge clk);
    #1;
    chk("busy_after_accept", 160'(in_tready), 160'(0));
    if (!hold) begin
      @(negedge clk);
      in_tvalid = 1'b0;
    end
  endtask

  // Count edges from acceptance to tvalid, then check the plaintext
  task automatic wait_out(input vec_t v, input string name);
    int e;
    int low;
    e   = 0;
    low = 0;
    while (!out_tvalid && e < 40) begin
      @(posedge clk);
      #1;
      e++;
      if (!in_tready) low++;
    end
    chk({name, "_latency"}, 160'(e), 160'(14));
    chk({name, "_busy_cycles"}, 160'(low), 160'(14));
    chk({name, "_tdata"}, 160'(out_tdata), 160'(v.pt));
    chk({name, "_tlast"}, 160'(out_tlast), 160'(v.last));
  endtask

  // Transfer completes on the next edge with tready high
  task automatic finish_xfer(input string name);
    @(posedge clk);
    #1;
    chk({name, "_tvalid_drop"}, 160'(out_tvalid), 160'(0));
    chk({name, "_ready_again"}, 160'(in_tready), 160'(1));
  endtask

  initial begin
    bit seen;

    vecs[0] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 128'h6bc1bee22e409f96e93d7e117393172a, 1'b0};
    vecs[1] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                128'h591ccb10d410ed26dc5ba74a31362870, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b0};
    vecs[2] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                128'hb6ed21b99ca6f4f9f153e7b1beafed1d, 128'h30c81c46a35ce411e5fbc1191a0a52ef, 1'b0};
    vecs[3] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                128'h23304b7a39f9f3ff067d8d8f9e24ecc7, 128'hf69f2445df4f9b17ad2b417be66c3710, 1'b1};
    vecs[4] = '{256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff, 1'b1};

    resetn     = 1'b0;
    round_keys = expand_key(vecs[0].key);
    keys_valid = 1'b1;
    in_tdata   = vecs[0].ct;
    in_tvalid  = 1'b1;
    in_tlast   = 1'b1;
    out_tready = 1'b1;

    // Reset state with keys valid and tvalid pending
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {out_tvalid, out_tlast, in_tready, out_tdata}, 160'(0));
    @(negedge clk);
    in_tvalid = 1'b0;
    resetn    = 1'b1;

    // Single block then a 4-block packet with tvalid held high between blocks
    for (int i = 0; i < 4; i++) begin
      send(vecs[i], 1'b1);
      wait_out(vecs[i], $sformatf("ecb%0d", i));
      finish_xfer($sformatf("ecb%0d", i));
    end
    @(negedge clk);
    in_tvalid = 1'b0;

    // Different key, isolated block
    send(vecs[4], 1'b0);
    wait_out(vecs[4], "fips");
    finish_xfer("fips");

    // Backpressure: 20 stalled cycles, keys dropping mid-stall
    @(negedge clk);
    out_tready = 1'b0;
    send(vecs[2], 1'b0);
    wait_out(vecs[2], "bp");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 5)  keys_valid = 1'b0;
      if (k == 10) keys_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("bp_stall%0d", k), {out_tvalid, in_tready, out_tlast, out_tdata},
          {1'b1, 1'b0, vecs[2].last, vecs[2].pt});
    end
    @(negedge clk);
    out_tready = 1'b1;
    finish_xfer("bp");

    // Keys not ready: tvalid held, no acceptance until keys valid
    @(negedge clk);
    round_keys = expand_key(vecs[1].key);
    keys_valid = 1'b0;
    in_tdata   = vecs[1].ct;
    in_tlast   = vecs[1].last;
    in_tvalid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("nokey_ready%0d", k), {out_tvalid, in_tready}, 160'(0));
    end
    @(negedge clk);
    keys_valid = 1'b1;
    #1;
    chk("nokey_ready_rises", 160'(in_tready), 160'(1));
    @(posedge clk);
    #1;
    chk("nokey_accepted", 160'(in_tready), 160'(0));
    @(negedge clk);
    in_tvalid = 1'b0;
    wait_out(vecs[1], "nokey");
    finish_xfer("nokey");

    // Key-valid drop at round 5 aborts the block
    send(vecs[3], 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    keys_valid = 1'b0;
    @(negedge clk);
    keys_valid = 1'b1;
    #1;
    chk("abort_back_idle", 160'(in_tready), 160'(1));
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_tvalid) seen = 1'b1;
    end
    chk("abort_no_output", 160'(seen), 160'(0));
    send(vecs[0], 1'b0);
    wait_out(vecs[0], "after_abort");
    finish_xfer("after_abort");

    // Async reset mid-ROUND, released between edges
    send(vecs[4], 1'b0);
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("rst_round_outputs", {out_tvalid, out_tlast, in_tready, out_tdata}, 160'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    send(vecs[1], 1'b0);
    wait_out(vecs[1], "after_rst_round");
    finish_xfer("after_rst_round");

    // Async reset while an output is stalled in DONE
    @(negedge clk);
    out_tready = 1'b0;
    send(vecs[3], 1'b0);
    wait_out(vecs[3], "pre_rst_done");
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_done_outputs", {out_tvalid, out_tlast, in_tready, out_tdata}, 160'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn     = 1'b1;
    out_tready = 1'b1;
    send(vecs[4], 1'b0);
    wait_out(vecs[4], "after_rst_done");
    finish_xfer("after_rst_done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes256_decrypt_iterative.md
Name: aes256_decrypt_iterative

Overview:
- AES-256 inverse cipher, FIPS-197 ECB decryption, on 128-bit AXI-Stream blocks.
- Consumes the round-key bundle from key_expansion, the same one that feeds the encryption pipeline.
- Uses one iterative round datapath reused 14 times. This trades throughput for area and is the receive-side counterpart of the unrolled encryption chain.

Parameters:
ROUNDS, 14, number of cipher rounds; only 14 (AES-256) is supported, and the round counter is sized from it.

Ports:
- clk  in  1  single clock domain, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- round_keys_i  in  round_keys_t (15x128)  round keys 0..14 from key_expansion.
- round_keys_valid_i  in  1  round keys stable and usable.
- aes_in_tdata  in  128  ciphertext block; bit 127 = byte 0 (FIPS-197 order).
- aes_in_tvalid  in  1  input valid.
- aes_in_tlast  in  1  last block of packet.
- aes_in_tready  out  1  block can accept a ciphertext.
- aes_out_tdata  out  128  plaintext block.
- aes_out_tvalid  out  1  output valid.
- aes_out_tlast  out  1  tlast carried through from the accepted input.
- aes_out_tready  in  1  downstream ready.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, round counter=0, state register=0, tlast register=0.
  - aes_out_tvalid=0, aes_out_tdata=0, aes_out_tlast=0, aes_in_tready=0.
- FSM states: IDLE, ROUND, DONE.
- aes_in_tready = (state==IDLE) && round_keys_valid_i. It is registered-state derived and has no combinational path from aes_in_tvalid.
- IDLE:
  - On aes_in_tvalid && aes_in_tready: state_reg <= aes_in_tdata ^ round_keys_i[14], tlast_reg <= aes_in_tlast, cnt <= 13, go ROUND.
  - Otherwise stay in IDLE.
- ROUND, one inverse round per clock:
  - While cnt>0: state_reg <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), round_keys_i[cnt])), then cnt <= cnt-1.
  - When cnt==0: apply the final round with no InvMixColumns, using round_keys_i[0], and go DONE.
- DONE:
  - aes_out_tvalid=1; aes_out_tdata=state_reg; aes_out_tlast=tlast_reg.
  - Data and tlast are held stable until aes_out_tready=1.
  - On that handshake go IDLE, and aes_out_tvalid deasserts next cycle.
- Latency and throughput:
  - aes_out_tvalid rises 14 clock edges after the accepting edge.
  - Minimum spacing is one block per 16 cycles: accept, 14 rounds, DONE with immediate tready. Input is not accepted while in ROUND or DONE.
- Arithmetic:
  - InvSubBytes uses 16 parallel inverse S-box lookups.
  - InvMixColumns uses GF(2^8) multiply by 0e/0b/0d/09 via xtime chains, polynomial 0x11B.
  - All datapath logic is purely combinational between registers.
- Round keys:
  - Keys are not latched; round_keys_i must stay stable from accept until DONE.
  - If round_keys_valid_i drops in ROUND: abort, go IDLE, produce no output, and drop the block.
  - round_keys_valid_i dropping in DONE does not affect the pending output.
- Backpressure: aes_out_tready held low in DONE stalls indefinitely with no data change. aes_in_tready stays 0 during the stall.
- Simultaneous events: an aes_in_tvalid that is asserted while not ready is ignored, and upstream must hold it (AXIS rule).
- Reset mid-operation: the in-flight block is discarded and all outputs return to their reset values immediately.

Test Plan:
- Single-block decrypt:
  - Stimulus: key_expansion with key 603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4; feed F3EED1BDB5D2A03C064B5A7E3DB181F8.
  - Response: aes_out_tdata=6BC1BEE22E409F96E93D7E117393172A, tvalid exactly 14 edges after accept, tlast=0.
- Four-block packet, back-to-back tvalid:
  - Stimulus: 591CCB10D410ED26DC5BA74A31362870, B6ED21B99CA6F4F9F153E7B1BEAFED1D, 23304B7A39F9F3FF067D8D8F9E24ECC7 (tlast=1) after block 1.
  - Response: plaintexts AE2D8A57..8E51, 30C81C46..52EF, F69F2445..3710 in order; tlast only on the 4th; tready low 15 cycles between accepts.
- Backpressure: aes_out_tready=0 for 20 cycles in DONE -> tvalid/tdata stable throughout, tready=0; one transfer occurs when tready rises, then back to IDLE.
- Keys not ready: round_keys_valid_i=0 with aes_in_tvalid=1 -> aes_in_tready=0 and no acceptance; once keys are valid, acceptance occurs on the next edge.
- Key-valid drop: deassert round_keys_valid_i at round 5 -> no aes_out_tvalid, FSM returns to IDLE; the next block decrypts correctly.
- Async reset mid-ROUND (resetn=0 for 2 cycles, between edges) -> outputs 0 immediately; after release the first block decrypts to the correct value.
